// File: rtl/row_decompressor_pkg.sv
// Shared decode definitions for the row compressor/decompressor pair:
// FSM encoding and the delta/literal byte-format constants.
package row_decompressor_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_CODE,
        S_LIT_HI,
        S_LIT_LO,
        S_OUT
    } decodeState_t;

    // A code byte is either a signed delta against the pixel above, or the escape
    // that introduces a two-byte literal sent high byte first.
    localparam int CodeBitWidth = 8;
    localparam int LiteralBitWidth = 2 * CodeBitWidth;
    localparam logic [CodeBitWidth-1:0] EscapeCodeDefault = 8'h80;

    function automatic logic [LiteralBitWidth-1:0] joinLiteral(
        input logic [CodeBitWidth-1:0] hiByte,
        input logic [CodeBitWidth-1:0] loByte
    );
        return {hiByte, loByte};
    endfunction

endpackage

// File: rtl/row_decompressor_line_buffer.sv
// One-row pixel store: simple dual-port RAM with a registered read port,
// written as a plain array so synthesis maps it onto block RAM.
module row_decompressor_line_buffer #(
    parameter  int Depth = 512,
    parameter  int Width = 16,
    localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 CLK,
    input  logic                 wrEn,
    input  logic [AddrWidth-1:0] wrAddr,
    input  logic [Width-1:0]     wrData,
    input  logic                 rdEn,
    input  logic [AddrWidth-1:0] rdAddr,
    output logic [Width-1:0]     rdData
);

    logic [Width-1:0] mem [Depth];

    // NOTE: the array and read register get no reset; a reset term would stop
    // block-RAM inference, and row 0 masks whatever the RAM holds at power-up.
    always_ff @(posedge CLK) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/row_decompressor.sv
// Rebuilds raster pixels from the delta/literal byte stream against the
// previous decoded row, emitting them on a valid/ready stream.
module row_decompressor
    import row_decompressor_pkg::*;
#(
    parameter int FrameWidth = 512,
    parameter int FrameHeight = 384,
    parameter int PixelBitWidth = 16,
    parameter logic [CodeBitWidth-1:0] EscapeCode = EscapeCodeDefault
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_frame_start,
    input  logic [CodeBitWidth-1:0]  i_byte,
    input  logic                     i_byte_valid,
    output logic                     o_byte_ready,
    output logic [PixelBitWidth-1:0] o_pixel,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_eol,
    output logic                     o_frame_done,
    output logic                     o_sync_err
);

    localparam int ColWidth = (FrameWidth > 1) ? $clog2(FrameWidth) : 1;
    localparam int RowWidth = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;
    localparam logic [ColWidth-1:0] LastCol = ColWidth'(FrameWidth - 1);
    localparam logic [RowWidth-1:0] LastRow = RowWidth'(FrameHeight - 1);

    decodeState_t state;
    logic [ColWidth-1:0] col;
    logic [RowWidth-1:0] row;
    logic [CodeBitWidth-1:0] litHi;

    logic [PixelBitWidth-1:0] aboveRaw;
    logic [PixelBitWidth-1:0] above;
    logic signed [PixelBitWidth-1:0] deltaExt;
    logic [PixelBitWidth-1:0] deltaPixel;
    logic [PixelBitWidth-1:0] literalPixel;
    logic [PixelBitWidth-1:0] nextPixel;
    logic byteAccept;
    logic pixelLoad;
    logic pixelTaken;

    // A frame start wins over any byte offered in the same cycle.
    assign byteAccept = o_byte_ready && i_byte_valid && !i_frame_start;
    assign pixelTaken = o_valid && i_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        above        = (row == '0) ? '0 : aboveRaw;
        deltaExt     = PixelBitWidth'($signed(i_byte));
        deltaPixel   = above + $unsigned(deltaExt);
        literalPixel = PixelBitWidth'(joinLiteral(litHi, i_byte));
        pixelLoad    = 1'b0;
        nextPixel    = deltaPixel;
        if (byteAccept) begin
            case (state)
                S_CODE: begin
                    pixelLoad = (i_byte != EscapeCode);
                end
                S_LIT_LO: begin
                    pixelLoad = 1'b1;
                    nextPixel = literalPixel;
                end
                default: begin
                    pixelLoad = 1'b0;
                end
            endcase
        end
    end

    // The decoded pixel lands in the line buffer at the column whose read the
    // FETCH cycle already consumed, so the next row sees it as its "above".
    row_decompressor_line_buffer #(
        .Depth(FrameWidth),
        .Width(PixelBitWidth)
    ) lineBuffer (
        .CLK   (CLK),
        .wrEn  (pixelLoad),
        .wrAddr(col),
        .wrData(nextPixel),
        .rdEn  (state == S_FETCH),
        .rdAddr(col),
        .rdData(aboveRaw)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= S_FETCH;
            col          <= '0;
            row          <= '0;
            litHi        <= '0;
            o_pixel      <= '0;
            o_valid      <= 1'b0;
            o_eol        <= 1'b0;
            o_byte_ready <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            if (i_frame_start) begin
                o_sync_err   <= (col != '0) || (row != '0) ||
                                !((state == S_FETCH) || (state == S_CODE));
                state        <= S_FETCH;
                col          <= '0;
                row          <= '0;
                litHi        <= '0;
                o_valid      <= 1'b0;
                o_eol        <= 1'b0;
                o_byte_ready <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        state        <= S_CODE;
                        o_byte_ready <= 1'b1;
                    end
                    S_CODE: begin
                        if (byteAccept) begin
                            if (i_byte == EscapeCode) begin
                                state <= S_LIT_HI;
                            end else begin
                                state        <= S_OUT;
                                o_byte_ready <= 1'b0;
                            end
                        end
                    end
                    S_LIT_HI: begin
                        if (byteAccept) begin
                            litHi <= i_byte;
                            state <= S_LIT_LO;
                        end
                    end
                    S_LIT_LO: begin
                        if (byteAccept) begin
                            state        <= S_OUT;
                            o_byte_ready <= 1'b0;
                        end
                    end
                    S_OUT: begin
                        if (pixelTaken) begin
                            o_valid <= 1'b0;
                            o_eol   <= 1'b0;
                            state   <= S_FETCH;
                            if (col == LastCol) begin
                                col <= '0;
                                if (row == LastRow) begin
                                    row          <= '0;
                                    o_frame_done <= 1'b1;
                                end else begin
                                    row <= row + RowWidth'(1);
                                end
                            end else begin
                                col <= col + ColWidth'(1);
                            end
                        end
                    end
                    default: begin
                        state        <= S_FETCH;
                        o_byte_ready <= 1'b0;
                    end
                endcase

                if (pixelLoad) begin
                    o_pixel <= nextPixel;
                    o_valid <= 1'b1;
                    o_eol   <= (col == LastCol);
                end
            end
        end
    end

endmodule
